// File: rtl/mole_if.sv
// mole_if: groups the mole request input and the LED/status outputs
//   number      - requested mole position (0..17 valid, 18..31 = no mole)
//   displayL    - one-hot LED bank, all zeros when no mole is lit
//   mole_active - high exactly when displayL is non-zero
//   expired     - one-cycle pulse when a lit mole times out
interface mole_if;
    logic [4:0]  number;
    logic [17:0] displayL;
    logic        mole_active;
    logic        expired;

    modport master (output number, input displayL, mole_active, expired);
    modport slave  (input number, output displayL, mole_active, expired);
endinterface

// File: rtl/mole.sv
// mole: lights one of 18 LEDs for MOLE_CYCLES cycles, with retarget and timeout
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mole_if slave: number in; displayL, mole_active, expired out
module mole #(
    parameter int MOLE_CYCLES = 50_000_000
) (
    input  logic   clk,
    input  logic   rst_n,
    mole_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHOW, EXPIRED} state_t;

    localparam logic [25:0] LAST = 26'(MOLE_CYCLES - 1);

    state_t      state, state_n;
    logic [4:0]  number_q, idx, idx_n;
    logic [25:0] cnt, cnt_n;
    logic        exp_n, valid;

    assign valid = number_q < 5'd18;

    // Invalid number beats retarget, which beats timeout.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        exp_n   = 1'b0;
        case (state)
            IDLE: if (valid) begin
                state_n = SHOW;
                idx_n   = number_q;
                cnt_n   = '0;
            end
            SHOW: if (!valid) begin
                state_n = IDLE;
            end else if (number_q != idx) begin
                idx_n = number_q;
                cnt_n = '0;
            end else if (cnt == LAST) begin
                state_n = EXPIRED;
                exp_n   = 1'b1;
            end else begin
                cnt_n = cnt + 26'd1;
            end
            EXPIRED: if (number_q != idx) begin
                state_n = valid ? SHOW : IDLE;
                idx_n   = number_q;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they change on
    // the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            number_q        <= 5'h1F;
            idx             <= 5'h1F;
            cnt             <= '0;
            bus.displayL    <= '0;
            bus.mole_active <= 1'b0;
            bus.expired     <= 1'b0;
        end else begin
            state           <= state_n;
            number_q        <= bus.number;
            idx             <= idx_n;
            cnt             <= cnt_n;
            bus.displayL    <= (state_n == SHOW) ? 18'b1 << idx_n : '0;
            bus.mole_active <= state_n == SHOW;
            bus.expired     <= exp_n;
        end
    end
endmodule

// File: tb/tb_mole.sv
// tb_mole: directed self-checking bench for mole with MOLE_CYCLES = 4
module tb_mole;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    mole_if bus ();

    mole #(.MOLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [17:0] disp, input logic act, input logic exp);
        vectors++;
        assert (bus.displayL === disp && bus.mole_active === act && bus.expired === exp)
        else begin
            errors++;
            $error("FAIL %s: got disp=%05h act=%b exp=%b, want disp=%05h act=%b exp=%b",
                   tag, bus.displayL, bus.mole_active, bus.expired, disp, act, exp);
        end
    endtask

    initial begin
        bus.number = 5'd16;
        tick(2);
        chk("reset", 18'h00000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("release_e1", 18'h00000, 1'b0, 1'b0);
        tick();
        chk("release_e2", 18'h10000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold16_lit", 18'h10000, 1'b1, 1'b0);
        end
        tick();
        chk("hold16_expire", 18'h00000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold16_dark", 18'h00000, 1'b0, 1'b0);
        end
        bus.number = 5'd3;
        tick();
        chk("n3_e1", 18'h00000, 1'b0, 1'b0);
        tick();
        chk("n3_e2", 18'h00008, 1'b1, 1'b0);

        bus.number = 5'd20;
        tick();
        chk("n20_e1", 18'h00008, 1'b1, 1'b0);
        tick();
        chk("n20_idle", 18'h00000, 1'b0, 1'b0);
        bus.number = 5'd17;
        tick(2);
        chk("n17", 18'h20000, 1'b1, 1'b0);
        bus.number = 5'd0;
        tick(2);
        chk("n0", 18'h00001, 1'b1, 1'b0);
        bus.number = 5'd31;
        tick(2);
        chk("n31_idle", 18'h00000, 1'b0, 1'b0);

        bus.number = 5'd5;
        tick(2);
        chk("n5", 18'h00020, 1'b1, 1'b0);
        tick();
        bus.number = 5'd9;
        tick();
        chk("n9_pending", 18'h00020, 1'b1, 1'b0);
        tick();
        chk("n9_lit", 18'h00200, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("n9_hold", 18'h00200, 1'b1, 1'b0);
        end
        tick();
        chk("n9_expire", 18'h00000, 1'b0, 1'b1);

        bus.number = 5'd2;
        tick(2);
        chk("n2_lit", 18'h00004, 1'b1, 1'b0);
        tick(2);
        bus.number = 5'd6;
        tick();
        chk("n2_cnt3", 18'h00004, 1'b1, 1'b0);
        tick();
        chk("retarget_wins", 18'h00040, 1'b1, 1'b0);
        tick();
        chk("retarget_noexp", 18'h00040, 1'b1, 1'b0);

        #2 rst_n = 1'b0;
        #1 chk("async_reset", 18'h00000, 1'b0, 1'b0);
        tick();
        chk("reset_held", 18'h00000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
